bit_shifter_pipelined: RTL and testbench

Parametrised, pipelined successor to the combinational multi-word bit shifter. It shifts a concatenation of WORD_COUNT words by a runtime amount, left or right, in logical, arithmetic or rotate mode. The shifter is split into registered log-shifter stages with valid/ready handshakes on both sides, so it can sit in streaming datapaths at full clock rate with backpressure.

---
 rtl/bit_shifter_pipelined_pkg.sv | 31 +++
 rtl/bit_shifter_stage.sv | 78 +++++++
 rtl/bit_shifter_pipelined.sv | 90 +++++++++
 tb/tb_bit_shifter_pipelined.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bit_shifter_pipelined_pkg.sv
// Shared constants, control bundle and helpers for the pipelined bit shifter.
// Imported by the stage module and the top level.
package bit_shifter_pipelined_pkg;

  localparam logic LEFT_SHIFT  = 1'b0;
  localparam logic RIGHT_SHIFT = 1'b1;

  typedef enum logic [1:0] {
    MODE_LOGICAL  = 2'b00,
    MODE_ARITH    = 2'b01,
    MODE_ROTATE   = 2'b10,
    MODE_RESERVED = 2'b11
  } mode_e;

  typedef struct packed {
    logic  dir;
    mode_e mode;
    logic  fill;
    logic  sat;
  } ctrl_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bit_shifter_stage.sv
// One registered log-shifter stage: resolves BITS_PER_STAGE amount bits
// and holds its result while the downstream side is stalled.
module bit_shifter_stage
  import bit_shifter_pipelined_pkg::*;
#(
  parameter int TOTAL_WIDTH    = 32,
  parameter int BITS_PER_STAGE = 2,
  parameter int STAGE_INDEX    = 0,
  parameter int AMOUNT_BITS    = 5
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   up_valid,
  input  logic                   ready,
  input  logic [TOTAL_WIDTH-1:0] up_data,
  input  logic [AMOUNT_BITS-1:0] up_amount,
  input  ctrl_t                  up_ctrl,
  output logic                   valid,
  output logic [TOTAL_WIDTH-1:0] data,
  output logic [AMOUNT_BITS-1:0] amount,
  output ctrl_t                  ctrl
);

  localparam int LO = STAGE_INDEX * BITS_PER_STAGE;
  localparam int HI = LO + BITS_PER_STAGE;

  logic [TOTAL_WIDTH-1:0] shifted;

  function automatic logic [TOTAL_WIDTH-1:0] shift_by(
    input logic [TOTAL_WIDTH-1:0] d,
    input int                     s,
    input ctrl_t                  c
  );
    logic [TOTAL_WIDTH-1:0] ones;
    logic [TOTAL_WIDTH-1:0] r;
    logic                   rot;
    ones = '1;
    rot  = (c.mode == MODE_ROTATE);
    r    = d;
    unique case (1'b1)
      rot && c.dir:
        r = (d >> s) | (d << (TOTAL_WIDTH - s));
      rot && !c.dir:
        r = (d << s) | (d >> (TOTAL_WIDTH - s));
      !rot && c.dir:
        r = (d >> s) | (c.fill ? ~(ones >> s) : '0);
      default:
        r = d << s;
    endcase
    return r;
  endfunction

  always_comb begin
    shifted = up_data;
    for (int j = 0; j < AMOUNT_BITS; j++) begin
      if (j >= LO && j < HI && up_amount[j])
        shifted = shift_by(shifted, 1 << j, up_ctrl);
    end
  end

  // Loads only when this stage is free or its content moves on.
  always_ff @(posedge clock) begin
    if (clear) begin
      valid  <= 1'b0;
      data   <= '0;
      amount <= '0;
      ctrl   <= '0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data   <= shifted;
        amount <= up_amount;
        ctrl   <= up_ctrl;
      end
    end
  end

endmodule

// File: rtl/bit_shifter_pipelined.sv
// Pipelined multi-word shifter: input decode, DEPTH log-shifter stages
// with valid/ready flow control, and the saturation output mux.
module bit_shifter_pipelined
  import bit_shifter_pipelined_pkg::*;
#(
  parameter int WORD_WIDTH     = 8,
  parameter int WORD_COUNT     = 4,
  parameter int BITS_PER_STAGE = 2
) (
  input  logic                              clock,
  input  logic                              clear,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WORD_WIDTH*WORD_COUNT-1:0]  in_data,
  input  logic [WORD_WIDTH-1:0]             in_shift_amount,
  input  logic                              in_shift_direction,
  input  logic [1:0]                        in_shift_mode,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WORD_WIDTH*WORD_COUNT-1:0]  out_data,
  output logic                              out_saturated
);

  localparam int TOTAL_WIDTH = WORD_WIDTH * WORD_COUNT;
  localparam int AMOUNT_BITS = clog2(TOTAL_WIDTH);
  localparam int DEPTH =
    (AMOUNT_BITS + BITS_PER_STAGE - 1) / BITS_PER_STAGE;

  logic [DEPTH:0]         valid;
  logic [DEPTH:0]         ready;
  logic [TOTAL_WIDTH-1:0] data [DEPTH+1];
  logic [AMOUNT_BITS-1:0] amount [DEPTH+1];
  ctrl_t                  ctrl [DEPTH+1];
  mode_e                  mode;
  logic                   unused_amount;

  assign mode = mode_e'(in_shift_mode);

  assign valid[0]  = in_valid;
  assign data[0]   = in_data;
  assign amount[0] = in_shift_amount[AMOUNT_BITS-1:0];
  assign ctrl[0]   = '{
    dir:  in_shift_direction,
    mode: mode,
    fill: (in_shift_direction == RIGHT_SHIFT) &&
          (mode == MODE_ARITH) && in_data[TOTAL_WIDTH-1],
    sat:  (|(in_shift_amount >> AMOUNT_BITS)) &&
          (mode != MODE_ROTATE)
  };

  // ready[k] is the load enable of stage k; ready[DEPTH] is the sink.
  always_comb begin
    ready        = '0;
    ready[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--)
      ready[k] = !valid[k+1] || ready[k+1];
  end

  assign in_ready = ready[0];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    bit_shifter_stage #(
      .TOTAL_WIDTH    (TOTAL_WIDTH),
      .BITS_PER_STAGE (BITS_PER_STAGE),
      .STAGE_INDEX    (k),
      .AMOUNT_BITS    (AMOUNT_BITS)
    ) u_stage (
      .clock     (clock),
      .clear     (clear),
      .up_valid  (valid[k]),
      .ready     (ready[k]),
      .up_data   (data[k]),
      .up_amount (amount[k]),
      .up_ctrl   (ctrl[k]),
      .valid     (valid[k+1]),
      .data      (data[k+1]),
      .amount    (amount[k+1]),
      .ctrl      (ctrl[k+1])
    );
  end

  assign unused_amount = ^amount[DEPTH];

  assign out_valid     = valid[DEPTH];
  assign out_saturated = ctrl[DEPTH].sat;
  assign out_data      = ctrl[DEPTH].sat ?
                         {TOTAL_WIDTH{ctrl[DEPTH].fill}} :
                         data[DEPTH];

endmodule

// File: tb/tb_bit_shifter_pipelined.sv
// Directed and streamed checks of bit_shifter_pipelined at its
// default 32-bit, 3-stage configuration.
module tb_bit_shifter_pipelined;

  logic        clock = 1'b0;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [7:0]  in_shift_amount;
  logic        in_shift_direction;
  logic [1:0]  in_shift_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_saturated;

  int total = 0;
  int bad   = 0;

  bit_shifter_pipelined dut (
    .clock              (clock),
    .clear              (clear),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_data            (in_data),
    .in_shift_amount    (in_shift_amount),
    .in_shift_direction (in_shift_direction),
    .in_shift_mode      (in_shift_mode),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_data           (out_data),
    .out_saturated      (out_saturated)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  amt;
    logic        dir;
    logic [1:0]  mode;
    logic [31:0] exp;
    logic        sat;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [31:0] d,
    input logic [7:0] a, input logic dir, input logic [1:0] mode);
    logic        sat;
    logic [4:0]  sh;
    logic [63:0] t;
    logic [31:0] r;
    sat = (a >= 8'd32) && (mode != 2'b10);
    sh  = a[4:0];
    if (mode == 2'b10) begin
      t = {d, d};
      if (dir) begin
        t = t >> sh;
        r = t[31:0];
      end else begin
        t = t << sh;
        r = t[63:32];
      end
    end else if (dir && mode == 2'b01) begin
      r = sat ? {32{d[31]}} : 32'($signed(d) >>> sh);
    end else if (dir) begin
      r = sat ? 32'd0 : d >> sh;
    end else begin
      r = sat ? 32'd0 : d << sh;
    end
    return {sat, r};
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic run_one(input vec_t v, input string name);
    int lat;
    in_valid           = 1'b1;
    in_data            = v.data;
    in_shift_amount    = v.amt;
    in_shift_direction = v.dir;
    in_shift_mode      = v.mode;
    out_ready          = 1'b1;
    #1;
    check({name, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick();
      lat++;
    end
    check({name, "_latency"}, lat, 3);
    check({name, "_data"}, out_data, v.exp);
    check({name, "_sat"}, 32'(out_saturated), 32'(v.sat));
    tick();
    check({name, "_drained"}, 32'(out_valid), 32'd0);
  endtask

  task automatic stream(input int n, input bit rnd, input string name);
    logic [32:0] q[$];
    logic [32:0] e;
    logic [31:0] cd, held;
    logic [7:0]  ca;
    logic        cdir, stall, held_sat, in_fire, out_fire;
    logic [1:0]  cm;
    int acc, got, cyc;
    acc = 0; got = 0; cyc = 0; stall = 1'b0;
    held = '0; held_sat = 1'b0;
    cd = $urandom; ca = 8'($urandom_range(0, 31));
    cdir = 1'($urandom_range(0, 1)); cm = 2'($urandom_range(0, 3));
    while (got < n && cyc < 20000) begin
      in_valid = (acc < n) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      in_data = cd; in_shift_amount = ca;
      in_shift_direction = cdir; in_shift_mode = cm;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc >= 5);
      #1;
      if (stall) begin
        check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
        check({name, "_hold_data"}, out_data, held);
        check({name, "_hold_sat"}, 32'(out_saturated), 32'(held_sat));
      end
      if (!rnd && (cyc == 3 || cyc == 4))
        check({name, "_full_in_ready"}, 32'(in_ready), 32'd0);
      if (!rnd && cyc == 5)
        check({name, "_retire_accept"}, 32'(in_ready), 32'd1);
      in_fire  = in_valid && in_ready;
      out_fire = out_valid && out_ready;
      stall    = out_valid && !out_ready;
      held     = out_data;
      held_sat = out_saturated;
      if (out_fire) begin
        got++;
        if (q.size() == 0) begin
          check({name, "_spurious"}, 32'(out_valid), 32'd0);
        end else begin
          e = q.pop_front();
          check({name, "_data"}, out_data, e[31:0]);
          check({name, "_sat"}, 32'(out_saturated), 32'(e[32]));
        end
      end
      if (in_fire) begin
        q.push_back(model(cd, ca, cdir, cm));
        acc++;
        cd = $urandom;
        ca = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(0, 31));
        cdir = 1'($urandom_range(0, 1));
        cm = 2'($urandom_range(0, 3));
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check({name, "_received"}, got, n);
    check({name, "_accepted"}, acc, n);
    check({name, "_queue_empty"}, q.size(), 0);
    repeat (4) begin
      tick();
      check({name, "_no_extra"}, 32'(out_valid), 32'd0);
    end
  endtask

  initial begin
    vecs[0]  = '{32'h000000FF, 8'd4,   1'b0, 2'b00, 32'h00000FF0, 1'b0};
    vecs[1]  = '{32'h000000FF, 8'd4,   1'b1, 2'b00, 32'h0000000F, 1'b0};
    vecs[2]  = '{32'h80000000, 8'd31,  1'b1, 2'b01, 32'hFFFFFFFF, 1'b0};
    vecs[3]  = '{32'h80000000, 8'd200, 1'b1, 2'b01, 32'hFFFFFFFF, 1'b1};
    vecs[4]  = '{32'h40000000, 8'd40,  1'b1, 2'b01, 32'h00000000, 1'b1};
    vecs[5]  = '{32'h00000001, 8'd1,   1'b1, 2'b10, 32'h80000000, 1'b0};
    vecs[6]  = '{32'h00000001, 8'd33,  1'b1, 2'b10, 32'h80000000, 1'b0};
    vecs[7]  = '{32'h12345678, 8'd8,   1'b0, 2'b10, 32'h34567812, 1'b0};
    vecs[8]  = '{32'hF0000000, 8'd4,   1'b1, 2'b11, 32'h0F000000, 1'b0};
    vecs[9]  = '{32'hA5A5A5A5, 8'd0,   1'b0, 2'b00, 32'hA5A5A5A5, 1'b0};
    vecs[10] = '{32'hA5A5A5A5, 8'd0,   1'b1, 2'b01, 32'hA5A5A5A5, 1'b0};
    vecs[11] = '{32'hA5A5A5A5, 8'd0,   1'b1, 2'b10, 32'hA5A5A5A5, 1'b0};
    vecs[12] = '{32'h80000001, 8'd31,  1'b0, 2'b00, 32'h80000000, 1'b0};
    vecs[13] = '{32'h12345678, 8'd255, 1'b0, 2'b00, 32'h00000000, 1'b1};
    vecs[14] = '{32'h12345678, 8'd255, 1'b1, 2'b10, 32'h2468ACF0, 1'b0};
    vecs[15] = '{32'h80000000, 8'd4,   1'b0, 2'b01, 32'h00000000, 1'b0};
    vecs[16] = '{32'h80000000, 8'd200, 1'b1, 2'b00, 32'h00000000, 1'b1};

    clear = 1'b1; in_valid = 1'b0; in_data = '0; in_shift_amount = '0;
    in_shift_direction = 1'b0; in_shift_mode = 2'b00; out_ready = 1'b0;
    tick(); tick();
    clear = 1'b0;
    #1;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_data", out_data, 32'd0);
    check("reset_out_sat", 32'(out_saturated), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    tick();

    for (int i = 0; i < 17; i++)
      run_one(vecs[i], $sformatf("vec%0d", i));

    stream(6, 1'b0, "burst");
    stream(1000, 1'b1, "random");

    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 32'h1111_0000 + i;
      in_shift_amount = 8'd1; in_shift_direction = 1'b0;
      in_shift_mode = 2'b00;
      tick();
    end
    in_valid = 1'b0;
    #1;
    check("flight_full", 32'(out_valid), 32'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_out_valid", 32'(out_valid), 32'd0);
    check("clear_out_data", out_data, 32'd0);
    check("clear_out_sat", 32'(out_saturated), 32'd0);
    check("clear_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (5) begin
      tick();
      check("clear_no_stale", 32'(out_valid), 32'd0);
    end
    run_one(vecs[7], "after_clear");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
